// File: rtl/rx_pkg.sv
// Shared types and sizing helpers for the UART byte-to-word assembler.
package rx_pkg;

    localparam logic [7:0] RX_ASCII_OFFSET = 8'd48;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

    function automatic int unsigned rx_bytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Byte-index width; a single-byte word still needs a 1-bit index.
    function automatic int unsigned rx_idx_w(input int unsigned data_w);
        int unsigned bytes;
        bytes = data_w / 8;
        return (bytes <= 1) ? 1 : $clog2(bytes);
    endfunction

endpackage

// File: rtl/rx_word_assembler_if.sv
// Byte-in / word-out bundle between the UART receiver and the MIPS loader.
interface rx_word_assembler_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              start;
    logic [7:0]        din;
    logic              out_ready;
    logic              go;
    logic [DATA_W-1:0] dout;
    logic [ADDR_W-1:0] rx_address;
    logic              MIPS_enable;
    logic              overrun;
    logic              timeout_err;

    modport master (
        output start, din, out_ready,
        input  go, dout, rx_address, MIPS_enable, overrun, timeout_err
    );

    modport slave (
        input  start, din, out_ready,
        output go, dout, rx_address, MIPS_enable, overrun, timeout_err
    );
endinterface

// File: rtl/rx_idle_timer.sv
// Inter-byte idle counter; expire is a combinational strobe on the cycle the
// count would reach TIMEOUT_CYC. TIMEOUT_CYC=0 builds no logic.
module rx_idle_timer #(
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    if (TIMEOUT_CYC == 0) begin : g_off
        logic w_unused;
        assign w_unused = &{1'b0, clk, reset, clear, run};
        assign expire   = 1'b0;
    end else begin : g_on
        localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

        logic [CNT_W-1:0] r_cnt;
        logic             w_hit;

        assign w_hit  = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
        // A byte arriving on the expiry cycle takes priority over the timeout.
        assign expire = run && !clear && w_hit;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt <= '0;
            end else if (clear || !run || w_hit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rx_word_assembler.sv
// Collects DATA_W/8 received bytes (first byte into the MSBs) into a held word
// with valid/ready handoff and an auto-incrementing load address.
// Define RX_ASCII_DECODE_EN to subtract ASCII '0' from every received byte.
module rx_word_assembler
    import rx_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ADDR_STEP   = 1,
    parameter int unsigned NUM_WORDS   = 64,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    rx_word_assembler_if.slave   bus
);

    localparam int unsigned BYTES = rx_bytes(DATA_W);
    localparam int unsigned IDX_W = rx_idx_w(DATA_W);
    localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_asm;
    logic [DATA_W-1:0] r_dout;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_count;
    logic              r_mips;
    logic              r_overrun;
    logic              r_timeout;
    hold_state_e       r_hold;
    hold_state_e       w_hold_nxt;

    logic [7:0]        w_byte;
    logic [DATA_W-1:0] w_word;
    logic              w_take;
    logic              w_complete;
    logic              w_accept;
    logic              w_run;
    logic              w_expire;
    logic              w_load;
    logic              w_drop;

`ifdef RX_ASCII_DECODE_EN
    assign w_byte = bus.din - RX_ASCII_OFFSET;
`else
    assign w_byte = bus.din;
`endif

    // Once the load is complete the receiver is ignored entirely.
    assign w_take     = bus.start && !r_mips;
    assign w_complete = w_take && (r_idx == LAST_IDX);
    assign w_accept   = (r_hold == HOLD_FULL) && bus.out_ready;
    assign w_run      = (r_idx != '0) && !r_mips;

    rx_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_take),
        .run    (w_run),
        .expire (w_expire)
    );

    // Completed word: assembled upper bytes plus the byte arriving now.
    always_comb begin
        w_word      = r_asm;
        w_word[7:0] = w_byte;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold <= HOLD_EMPTY;
        end else begin
            r_hold <= w_hold_nxt;
        end
    end

    always_comb begin
        w_hold_nxt = r_hold;
        w_load     = 1'b0;
        w_drop     = 1'b0;
        case (r_hold)
            HOLD_EMPTY: begin
                if (w_complete) begin
                    w_load     = 1'b1;
                    w_hold_nxt = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                if (w_complete && bus.out_ready) begin
                    w_load = 1'b1;
                end else if (w_complete) begin
                    w_drop = 1'b1;
                end else if (bus.out_ready) begin
                    w_hold_nxt = HOLD_EMPTY;
                end
            end
            default: w_hold_nxt = HOLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
        end else if (w_take) begin
            r_idx <= w_complete ? '0 : r_idx + IDX_W'(1);
        end else if (w_expire) begin
            r_idx <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_asm <= '0;
        end else if (w_take) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (r_idx == IDX_W'(b)) begin
                    r_asm[DATA_W-1-8*b -: 8] <= w_byte;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout    <= '0;
            r_addr    <= '0;
            r_count   <= '0;
            r_mips    <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (w_load) begin
                r_dout <= w_word;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_accept) begin
                r_addr <= r_addr + ADDR_W'(ADDR_STEP);
                // Count saturates at NUM_WORDS; address keeps stepping.
                if (!r_mips) begin
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(NUM_WORDS - 1)) begin
                        r_mips <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.go          = (r_hold == HOLD_FULL);
    assign bus.dout        = r_dout;
    assign bus.rx_address  = r_addr;
    assign bus.MIPS_enable = r_mips;
    assign bus.overrun     = r_overrun;
    assign bus.timeout_err = r_timeout;

endmodule

// File: tb/tb_rx_word_assembler.sv
// Scoreboard bench: instance A uses the default parameters, instance B has
// NUM_WORDS=3, ADDR_STEP=4 and TIMEOUT_CYC=10.
module tb_rx_word_assembler;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rx_word_assembler_if #(.DATA_W(32), .ADDR_W(32)) ifa ();
    rx_word_assembler_if #(.DATA_W(32), .ADDR_W(32)) ifb ();

    rx_word_assembler #(
        .DATA_W(32), .ADDR_W(32), .ADDR_STEP(1), .NUM_WORDS(64), .TIMEOUT_CYC(0)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    rx_word_assembler #(
        .DATA_W(32), .ADDR_W(32), .ADDR_STEP(4), .NUM_WORDS(3), .TIMEOUT_CYC(10)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] a;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte the receiver must send so that the decoded value equals v.
    function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef RX_ASCII_DECODE_EN
        return v + 8'd48;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_a(input logic [7:0] v);
        ifa.start = 1'b1;
        ifa.din   = enc(v);
        tick();
        ifa.start = 1'b0;
    endtask

    task automatic put_b(input logic [7:0] v);
        ifb.start = 1'b1;
        ifb.din   = enc(v);
        tick();
        ifb.start = 1'b0;
    endtask

    task automatic word_a(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) put_a(w[8*i +: 8]);
    endtask

    task automatic word_b(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) put_b(w[8*i +: 8]);
    endtask

    // Monitors: every handshake must match the oldest expected word.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (reset && ifa.go && ifa.out_ready) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL a_unexpected: got 0x%0h @0x%0h, expected no word", ifa.dout, ifa.rx_address);
            end else begin
                e = qa.pop_front();
                chk("a_dout", {32'd0, ifa.dout}, {32'd0, e.d});
                chk("a_addr", {32'd0, ifa.rx_address}, {32'd0, e.a});
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (reset && ifb.go && ifb.out_ready) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_unexpected: got 0x%0h @0x%0h, expected no word", ifb.dout, ifb.rx_address);
            end else begin
                e = qb.pop_front();
                chk("b_dout", {32'd0, ifb.dout}, {32'd0, e.d});
                chk("b_addr", {32'd0, ifb.rx_address}, {32'd0, e.a});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        reset         = 1'b0;
        ifa.start     = 1'b0;
        ifa.din       = 8'd0;
        ifa.out_ready = 1'b0;
        ifb.start     = 1'b0;
        ifb.din       = 8'd0;
        ifb.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_a_go",   64'(ifa.go), 64'd0);
        chk("rst_a_dout", 64'(ifa.dout), 64'd0);
        chk("rst_a_addr", 64'(ifa.rx_address), 64'd0);
        chk("rst_a_mips", 64'(ifa.MIPS_enable), 64'd0);
        chk("rst_a_ovr",  64'(ifa.overrun), 64'd0);
        chk("rst_b_tmo",  64'(ifb.timeout_err), 64'd0);
        reset = 1'b1;
        tick();

        // Single word, go high for exactly one cycle
        ifa.out_ready = 1'b1;
        qa.push_back({32'h0102_0304, 32'd0});
        word_a(32'h0102_0304);
        chk("t1_go_hi", 64'(ifa.go), 64'd1);
        chk("t1_dout",  64'(ifa.dout), 64'h0102_0304);
        tick();
        chk("t1_go_lo", 64'(ifa.go), 64'd0);
        chk("t1_addr",  64'(ifa.rx_address), 64'd1);

        // Two back-to-back words
        qa.push_back({32'hDEAD_BEEF, 32'd1});
        qa.push_back({32'h0011_2233, 32'd2});
        word_a(32'hDEAD_BEEF);
        word_a(32'h0011_2233);
        tick();
        chk("t2_addr", 64'(ifa.rx_address), 64'd3);
        chk("t2_go",   64'(ifa.go), 64'd0);

        // Overrun: second word dropped while first is held
        ifa.out_ready = 1'b0;
        qa.push_back({32'h1122_3344, 32'd3});
        word_a(32'h1122_3344);
        chk("t3_ovr_pre", 64'(ifa.overrun), 64'd0);
        word_a(32'h5566_7788);
        chk("t3_ovr",  64'(ifa.overrun), 64'd1);
        chk("t3_dout", 64'(ifa.dout), 64'h1122_3344);
        chk("t3_go",   64'(ifa.go), 64'd1);
        chk("t3_addr_hold", 64'(ifa.rx_address), 64'd3);
        ifa.out_ready = 1'b1;
        tick();
        chk("t3_go_lo", 64'(ifa.go), 64'd0);
        chk("t3_addr",  64'(ifa.rx_address), 64'd4);
        chk("t3_ovr_sticky", 64'(ifa.overrun), 64'd1);

        // Timeout discards a partial word
        ifb.out_ready = 1'b1;
        put_b(8'h55);
        put_b(8'h66);
        repeat (9) tick();
        chk("t4_tmo_early", 64'(ifb.timeout_err), 64'd0);
        tick();
        chk("t4_tmo_pulse", 64'(ifb.timeout_err), 64'd1);
        tick();
        chk("t4_tmo_end", 64'(ifb.timeout_err), 64'd0);
        qb.push_back({32'hA0A1_A2A3, 32'd0});
        word_b(32'hA0A1_A2A3);
        tick();
        chk("t4_addr", 64'(ifb.rx_address), 64'd4);

        // Byte on the expiry cycle wins over the timeout
        qb.push_back({32'hC0C1_C2C3, 32'd4});
        put_b(8'hC0);
        put_b(8'hC1);
        repeat (9) tick();
        put_b(8'hC2);
        chk("t4_race_tmo", 64'(ifb.timeout_err), 64'd0);
        put_b(8'hC3);
        tick();
        chk("t4_race_addr", 64'(ifb.rx_address), 64'd8);
        chk("t4_mips_lo",   64'(ifb.MIPS_enable), 64'd0);

        // Third acceptance completes the load
        qb.push_back({32'h0F1E_2D3C, 32'd8});
        word_b(32'h0F1E_2D3C);
        chk("t5_mips_pre", 64'(ifb.MIPS_enable), 64'd0);
        tick();
        chk("t5_mips",  64'(ifb.MIPS_enable), 64'd1);
        chk("t5_addr",  64'(ifb.rx_address), 64'd12);
        word_b(32'h0101_0101);
        tick();
        chk("t5_no_go",  64'(ifb.go), 64'd0);
        chk("t5_no_ovr", 64'(ifb.overrun), 64'd0);
        chk("t5_addr_hold", 64'(ifb.rx_address), 64'd12);

        // Asynchronous reset mid-word
        put_a(8'h77);
        put_a(8'h88);
        put_a(8'h99);
        reset = 1'b0;
        #1;
        chk("t6_go",   64'(ifa.go), 64'd0);
        chk("t6_dout", 64'(ifa.dout), 64'd0);
        chk("t6_addr", 64'(ifa.rx_address), 64'd0);
        chk("t6_ovr",  64'(ifa.overrun), 64'd0);
        chk("t6_b_mips", 64'(ifb.MIPS_enable), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        qa.push_back({32'h0A0B_0C0D, 32'd0});
        word_a(32'h0A0B_0C0D);
        tick();
        chk("t6_addr_after", 64'(ifa.rx_address), 64'd1);

        repeat (2) tick();
        chk("sb_a_drain", 64'(qa.size()), 64'd0);
        chk("sb_b_drain", 64'(qb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rx_word_assembler.md
# rx_word_assembler

Parametrised byte-to-word assembler between the UART receiver and the MIPS program/data loader. Collects `DATA_W/8` byte strobes into a word (first byte → MSBs), holds it in an output register with a valid/ready handshake, and tags it with an auto-incrementing load address. It also discards stale partial words on an inter-byte timeout, flags overruns, and asserts `MIPS_enable` once `NUM_WORDS` words have been accepted.

## Interface
- `DATA_W`, 32, assembled word width; must be a multiple of 8, ≥ 8.
- `ADDR_W`, 32, width of `rx_address`.
- `ADDR_STEP`, 1, address increment per accepted word.
- `NUM_WORDS`, 64, words accepted before the load is complete; ≥ 1.
- `TIMEOUT_CYC`, 0, idle cycles before a partial word is discarded; 0 disables the timeout.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  byte strobe, one cycle per received byte.
- `din`  in  8  received byte, valid when `start`=1.
- `out_ready`  in  1  consumer accepts the held word.
- `go`  out  1  held word valid.
- `dout`  out  DATA_W  held word.
- `rx_address`  out  ADDR_W  address of the held word.
- `MIPS_enable`  out  1  load complete; sticky until reset.
- `overrun`  out  1  sticky: a completed word was dropped.
- `timeout_err`  out  1  one-cycle pulse: a partial word was discarded.

## Operation
- Reset (`reset`=0, async): all outputs and all state go to 0. `go`=0, `dout`=0, `rx_address`=0, `MIPS_enable`=0, `overrun`=0, `timeout_err`=0, byte index=0, accepted-word count=0.
- Byte FSM states: `COLLECT[k]`, k = 0..BYTES-1. A `start` in state k writes `dec(din)` into assembly bits `[DATA_W-1-8k -: 8]` and advances to k+1. A `start` in state BYTES-1 completes the word and returns to k=0.
- `dec(din)` is `din` by default. See Configuration.
- Hold register FSM states: `EMPTY` and `FULL` (`go`=1 iff `FULL`).
- Word completion while `EMPTY`, or while `FULL` with `out_ready`=1 in the same cycle: load the hold register and go (or stay) `FULL`.
- Word completion while `FULL` with `out_ready`=0: the completed word is dropped, `overrun`←1, and the hold register is unchanged.
- Acceptance: `go`&&`out_ready` on a rising edge.
  - Word count increments.
  - `rx_address` += `ADDR_STEP` (mod 2^ADDR_W, wraps silently); this becomes the address of the next word.
  - `FULL`→`EMPTY` unless a new word loads in the same cycle.
- After the `NUM_WORDS`-th acceptance: `MIPS_enable`←1. Thereafter `start` is ignored (no collection, no overrun, no timeout).
- Timeout (`TIMEOUT_CYC`>0): an idle counter runs while k≠0 and clears on every `start`.
  - When it reaches `TIMEOUT_CYC`: k←0, partial data is discarded, and `timeout_err` pulses for one cycle.
  - A `start` arriving in the same cycle as expiry wins: the byte is taken and no timeout occurs.
- Assembly bits not yet written for the current word retain stale values. Only the hold register is visible on `dout`.

## Timing
- Final byte `start` at edge N → `go`=1 and new `dout` after edge N. Latency is 1 cycle; `dout`/`go` are registered.
- `dout` and `rx_address` are stable while `go`=1 and `out_ready`=0.
- `go` falls one cycle after acceptance unless back-to-back completion reloads the register.
- Full throughput: one word per BYTES cycles with `start` every cycle and `out_ready` tied high.
- `MIPS_enable` rises on the edge after the final acceptance.
- `timeout_err` is high for the cycle following expiry.
- `reset` asserted mid-word or mid-handshake: everything clears immediately, with no pending word retained.

## Configuration
- `RX_ASCII_DECODE_EN` defined: `dec(din) = din - 8'd48`, 8-bit wrap (ASCII digit → value; `'A'`=0x41→0x11).
- `RX_ASCII_DECODE_EN` undefined: `dec(din) = din`, raw binary pass-through.

## Structure
- Shared package `rx_pkg`:
  - `RX_ASCII_OFFSET` = 8'd48.
  - Hold-state enum (`HOLD_EMPTY`, `HOLD_FULL`).
  - Function computing `BYTES = DATA_W/8` and the byte-index width `$clog2(BYTES)` (minimum 1).
- Sub-module `rx_idle_timer`:
  - Ports: `clk`, `reset`, `clear`, `run`, `expire`.
  - Parameter `TIMEOUT_CYC`.
  - Generates nothing when `TIMEOUT_CYC`=0, with `expire` tied to 0.

## Test plan
- DATA_W=32, macro on, bytes `'1','2','3','4'` on consecutive cycles, `out_ready`=1 → `dout`=0x01020304, `rx_address`=0, `go` high one cycle.
- Macro off, two words 0xDE,0xAD,0xBE,0xEF / 0x00,0x11,0x22,0x33 → 0xDEADBEEF@0, then 0x00112233@1.
- `out_ready`=0, two full words sent → first word held, `overrun`=1, `dout` is still the first word. Raise `out_ready` → accepted, `go` drops, `rx_address`=1.
- `TIMEOUT_CYC`=10, send 2 bytes, idle 10 cycles → `timeout_err` pulse. Then 4 bytes 0xA0..0xA3 → `dout`=0xA0A1A2A3.
- `NUM_WORDS`=3, ADDR_STEP=4: after the third acceptance → `MIPS_enable`=1, `rx_address`=12, and further `start` produces no `go`.
- Assert `reset`=0 after 3 of 4 bytes → all outputs 0. The next 4 bytes assemble cleanly at address 0.
